// File: rtl/csa_resolve_if.sv
// rtl/csa_resolve_if.sv - carry-save pair in / binary result out handshake bundle
interface csa_resolve_if #(
    parameter int SIZE = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [SIZE-1:0]  in_sum;
    logic [SIZE-1:0]  in_cout;
    logic             out_valid;
    logic             out_ready;
    logic [SIZE+1:0]  out_result;

    modport master (
        output in_valid, in_sum, in_cout, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_sum, in_cout, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/csa_resolve.sv
// rtl/csa_resolve.sv - CHUNK-bits-per-clock carry-propagate resolver of a carry-save pair
// Optional early termination on all-zero remainder: define CSA_RESOLVE_EARLY_EN.
module csa_resolve #(
    parameter int SIZE  = 16,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    csa_resolve_if.slave  bus
);
    localparam int NCH = (SIZE + 1 + CHUNK - 1) / CHUNK;
    localparam int W   = NCH * CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic             carry;
    logic [KW-1:0]    k;
    logic [SIZE+1:0]  res;
    logic             in_ready_r;
    logic             out_valid_r;

    logic             c_nxt;
    logic [CHUNK-1:0] r_nxt;
    logic [W+1:0]     res_upd;
    logic             finish;
    logic             unused_hi;

    always_comb begin
        {c_nxt, r_nxt} = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, carry};
        res_upd = (W + 2)'(res);
        res_upd[int'(k) * CHUNK +: CHUNK] = r_nxt;
        finish = (k == KW'(NCH - 1));
        // The final carry lands at bit W; only bits up to SIZE+1 are kept.
        if (finish) begin
            res_upd[W] = c_nxt;
        end
`ifdef CSA_RESOLVE_EARLY_EN
        if (!c_nxt && ((a_sh >> CHUNK) == '0) && ((b_sh >> CHUNK) == '0)) begin
            finish = 1'b1;
            for (int i = 0; i < W + 2; i++) begin
                if (i >= (int'(k) + 1) * CHUNK) begin
                    res_upd[i] = 1'b0;
                end
            end
        end
`endif
        unused_hi = ^res_upd[W+1:SIZE+2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            carry       <= 1'b0;
            k           <= '0;
            res         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh       <= W'({bus.in_sum[SIZE-1], bus.in_sum});
                        b_sh       <= W'({bus.in_cout, 1'b0});
                        carry      <= 1'b0;
                        k          <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    res   <= res_upd[SIZE+1:0];
                    carry <= c_nxt;
                    k     <= k + 1'b1;
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    if (finish) begin
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_result = res;
endmodule

// File: tb/tb_csa_resolve.sv
// tb/tb_csa_resolve.sv - directed and random check of csa_resolve against an arithmetic model
module tb_csa_resolve;
    localparam int SIZE  = 16;
    localparam int CHUNK = 4;
    localparam int NCH   = (SIZE + 1 + CHUNK - 1) / CHUNK;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    csa_resolve_if #(.SIZE(SIZE)) bus ();

    csa_resolve #(.SIZE(SIZE), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [15:0] s, input logic [15:0] c);
        longint a;
        longint b;
        a = longint'({s[15], s});
        b = longint'(c) * 2;
        return 32'((a + b) % (longint'(1) << (SIZE + 2)));
    endfunction

    function automatic int model_latency(input logic [15:0] s, input logic [15:0] c);
        longint a;
        longint b;
        longint m;
        a = longint'({s[15], s});
        b = longint'(c) * 2;
        m = 1;
`ifdef CSA_RESOLVE_EARLY_EN
        for (int n = 1; n < NCH; n++) begin
            m = longint'(1) << (CHUNK * n);
            if ((a / m) == 0 && (b / m) == 0 && (a % m) + (b % m) < m) return n;
        end
`endif
        if (m < 0) return 0;
        return NCH;
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready_wait"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic send(input logic [15:0] s, input logic [15:0] c);
        bus.in_valid = 1'b1;
        bus.in_sum   = s;
        bus.in_cout  = c;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sum   = $urandom;
        bus.in_cout  = $urandom;
    endtask

    task automatic wait_done(input string tag, input logic [15:0] s, input logic [15:0] c);
        int lat;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(model_latency(s, c)));
        check({tag, "_result"}, 32'(bus.out_result), model_result(s, c));
        check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_pair(input string tag, input logic [15:0] s, input logic [15:0] c);
        wait_ready(tag);
        send(s, c);
        wait_done(tag, s, c);
        drain(tag);
    endtask

    initial begin
        logic [31:0] held;
        logic [15:0] rs;
        logic [15:0] rc;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_cout   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", 32'(bus.out_result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_pair("csa_10_20_30", 16'h0000, 16'd30);
        run_pair("csa_5_6_7", 16'd4, 16'd7);
        run_pair("neg_ffff", 16'hFFFF, 16'h0000);
        run_pair("carry_chain", 16'hFFFF, 16'h0001);

        // Backpressure: result held, new offers ignored while DONE.
        wait_ready("bp");
        send(16'h1234, 16'h0F0F);
        wait_done("bp", 16'h1234, 16'h0F0F);
        held = 32'(bus.out_result);
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = i[0];
            bus.in_sum   = $urandom;
            bus.in_cout  = $urandom;
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_held", 32'(bus.out_result), held);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        drain("bp");
        run_pair("after_bp", 16'h8000, 16'h7FFF);

        // Reset during RUN after two chunks.
        wait_ready("rst_mid");
        send(16'hFFFF, 16'h0001);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mid_out_result", 32'(bus.out_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_pair("post_rst", 16'h0000, 16'd30);

        for (int t = 0; t < 24; t++) begin
            rs = 16'($urandom);
            rc = 16'($urandom);
            if (t % 4 == 1) rc = 16'($urandom_range(0, 15));
            if (t % 4 == 2) rs = 16'($urandom_range(0, 255));
            run_pair("random", rs, rc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
